// File: rtl/ifft4_pkg.sv
// ifft4_pkg: shared types, sizes and arithmetic helpers for the 4-point
// inverse FFT datapath.
//
// Contents:
//   WIDTH / HALF   packed complex width and per-half width (Q1.11 halves)
//   SIZE / LOG2_SIZE  transform length and its log2 (stall_out delay)
//   sat12          clamp a 13-bit sum to the 12-bit signed range
//   rnd_shr1       (s+1)>>>1, halving with round-half-toward-+inf
//   reduce13       per-build reduction of a 13-bit stage result
//   neg_sat        saturating negate (used by the +j rotation)
//
// Build option: IFFT4_SCALE_EN selects rnd_shr1 scaling in reduce13,
// otherwise each stage saturates.
package ifft4_pkg;

  localparam int WIDTH     = 24;
  localparam int SIZE      = 4;
  localparam int HALF      = WIDTH / 2;
  localparam int LOG2_SIZE = $clog2(SIZE);

  typedef logic signed [HALF-1:0] half_t;
  typedef logic        [WIDTH-1:0] cplx_t;

  localparam half_t HALF_MAX = {1'b0, {(HALF-1){1'b1}}};
  localparam half_t HALF_MIN = {1'b1, {(HALF-1){1'b0}}};

  function automatic half_t sat12(input logic signed [HALF:0] s);
    logic signed [HALF:0] hi;
    logic signed [HALF:0] lo;
    half_t r;
    hi = {1'b0, HALF_MAX};
    lo = {1'b1, HALF_MIN};
    if (s > hi)      r = HALF_MAX;
    else if (s < lo) r = HALF_MIN;
    else             r = s[HALF-1:0];
    return r;
  endfunction

  // One extra bit of headroom so s+1 cannot wrap before the shift.
  function automatic half_t rnd_shr1(input logic signed [HALF:0] s);
    logic signed [HALF+1:0] t;
    t = {s[HALF], s} + {{(HALF+1){1'b0}}, 1'b1};
    return t[HALF:1];
  endfunction

  function automatic half_t reduce13(input logic signed [HALF:0] s);
`ifdef IFFT4_SCALE_EN
    return rnd_shr1(s);
`else
    return sat12(s);
`endif
  endfunction

  // -(-2048) is not representable in 12 bits, so it clamps to +2047.
  function automatic half_t neg_sat(input half_t v);
    half_t r;
    if (v == HALF_MIN) r = HALF_MAX;
    else               r = -v;
    return r;
  endfunction

endpackage

// File: rtl/ifft4_if.sv
// ifft4_if: frame bus for the 4-point inverse FFT.
//
// Signals:
//   stall          pipeline hold request from downstream
//   valid_in       x*_in carry a frame this cycle
//   x0_in..x3_in   frequency bins X[0]..X[3], packed {re, im}
//   valid_out      x*_out carry a frame
//   stall_out      stall delayed by LOG2(size) cycles
//   x0_out..x3_out time samples x[0]..x[3], natural order
//
// Modports: master drives the inputs of the transform, slave is the
// transform itself.
interface ifft4_if;
  import ifft4_pkg::*;

  logic  stall;
  logic  valid_in;
  cplx_t x0_in;
  cplx_t x1_in;
  cplx_t x2_in;
  cplx_t x3_in;
  logic  valid_out;
  logic  stall_out;
  cplx_t x0_out;
  cplx_t x1_out;
  cplx_t x2_out;
  cplx_t x3_out;

  modport master (
    output stall, valid_in, x0_in, x1_in, x2_in, x3_in,
    input  valid_out, stall_out, x0_out, x1_out, x2_out, x3_out
  );

  modport slave (
    input  stall, valid_in, x0_in, x1_in, x2_in, x3_in,
    output valid_out, stall_out, x0_out, x1_out, x2_out, x3_out
  );

endinterface

// File: rtl/ifft4_ibfly2.sv
// ibfly2: registered radix-2 inverse butterfly.
//
// Ports:
//   clk, rst   clock and asynchronous active-low reset
//   stall      high: output registers hold
//   mul_j      high: difference output is rotated by +j
//   a, b       packed complex operands
//   y0         reduce(a + b)
//   y1         reduce(a - b), optionally multiplied by +j
//
// Reduction of each 13-bit half follows IFFT4_SCALE_EN (see ifft4_pkg).
module ibfly2
  import ifft4_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  stall,
  input  logic  mul_j,
  input  cplx_t a,
  input  cplx_t b,
  output cplx_t y0,
  output cplx_t y1
);

  half_t a_re, a_im, b_re, b_im;
  half_t dif_re_r, dif_im_r;
  logic signed [HALF:0] sum_re, sum_im, dif_re, dif_im;
  cplx_t y0_d, y1_d;
  cplx_t y0_q, y1_q;

  always_comb begin
    a_re   = a[WIDTH-1:HALF];
    a_im   = a[HALF-1:0];
    b_re   = b[WIDTH-1:HALF];
    b_im   = b[HALF-1:0];
    sum_re = {a_re[HALF-1], a_re} + {b_re[HALF-1], b_re};
    sum_im = {a_im[HALF-1], a_im} + {b_im[HALF-1], b_im};
    dif_re = {a_re[HALF-1], a_re} - {b_re[HALF-1], b_re};
    dif_im = {a_im[HALF-1], a_im} - {b_im[HALF-1], b_im};
    dif_re_r = reduce13(dif_re);
    dif_im_r = reduce13(dif_im);
    y0_d = {reduce13(sum_re), reduce13(sum_im)};
    // +j rotation (re, im) -> (-im, re) is applied after reduction.
    if (mul_j) y1_d = {neg_sat(dif_im_r), dif_re_r};
    else       y1_d = {dif_re_r, dif_im_r};
    if (stall) begin
      y0_d = y0_q;
      y1_d = y1_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y0_q <= '0;
      y1_q <= '0;
    end else begin
      y0_q <= y0_d;
      y1_q <= y1_d;
    end
  end

  assign y0 = y0_q;
  assign y1 = y1_q;

endmodule

// File: rtl/ifft4.sv
// ifft4: four-point inverse FFT, three-stage registered pipeline
// (input register P0 -> butterfly stage 0 P1 -> butterfly stage 1 P2).
//
// Ports:
//   clk   single clock, rising edge
//   rst   asynchronous active-low reset
//   bus   ifft4_if.slave: stall, valid_in, x0..x3_in in;
//         valid_out, stall_out, x0..x3_out out
//
// Build option: IFFT4_SCALE_EN halves every stage (true 1/4-scaled IDFT);
// without it each stage saturates and the output is the unscaled sum.
module ifft4
  import ifft4_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  ifft4_if.slave  bus
);

  cplx_t [3:0] x_d, x_q;
  logic  [2:0] valid_d, valid_q;
  logic  [LOG2_SIZE-1:0] stall_pipe_d, stall_pipe_q;
  cplx_t a1_0, a1_1, a1_2, a1_3;
  cplx_t a2_0, a2_1, a2_2, a2_3;

  // Input capture and valid tracking freeze on stall; the stall_out
  // delay line deliberately keeps shifting so downstream sees the delay.
  always_comb begin
    x_d          = {bus.x3_in, bus.x2_in, bus.x1_in, bus.x0_in};
    valid_d      = {valid_q[1:0], bus.valid_in};
    stall_pipe_d = {stall_pipe_q[LOG2_SIZE-2:0], bus.stall};
    if (bus.stall) begin
      x_d     = x_q;
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q          <= '0;
      valid_q      <= '0;
      stall_pipe_q <= '0;
    end else begin
      x_q          <= x_d;
      valid_q      <= valid_d;
      stall_pipe_q <= stall_pipe_d;
    end
  end

  ibfly2 u_s0_even (.clk(clk), .rst(rst), .stall(bus.stall), .mul_j(1'b0),
                    .a(x_q[0]), .b(x_q[2]), .y0(a1_0), .y1(a1_2));
  ibfly2 u_s0_odd  (.clk(clk), .rst(rst), .stall(bus.stall), .mul_j(1'b1),
                    .a(x_q[1]), .b(x_q[3]), .y0(a1_1), .y1(a1_3));
  ibfly2 u_s1_lo   (.clk(clk), .rst(rst), .stall(bus.stall), .mul_j(1'b0),
                    .a(a1_0), .b(a1_1), .y0(a2_0), .y1(a2_1));
  ibfly2 u_s1_hi   (.clk(clk), .rst(rst), .stall(bus.stall), .mul_j(1'b0),
                    .a(a1_2), .b(a1_3), .y0(a2_2), .y1(a2_3));

  // Stage 1 produces bit-reversed order; swap the middle pair here.
  assign bus.x0_out    = a2_0;
  assign bus.x1_out    = a2_2;
  assign bus.x2_out    = a2_1;
  assign bus.x3_out    = a2_3;
  assign bus.valid_out = valid_q[2];
  assign bus.stall_out = stall_pipe_q[LOG2_SIZE-1];

endmodule

// File: tb/tb_ifft4.sv
// tb_ifft4: directed bench for ifft4. Expected values are hand-computed
// for whichever build (IFFT4_SCALE_EN defined or not) is compiled.
`timescale 1ns/1ps
module tb_ifft4;
  import ifft4_pkg::*;

`ifdef IFFT4_SCALE_EN
  localparam int SCL = 4;
`else
  localparam int SCL = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  ifft4_if bus();

  ifft4 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic cplx_t cx(input int re, input int im);
    logic [31:0] r;
    logic [31:0] i;
    r = re;
    i = im;
    return {r[HALF-1:0], i[HALF-1:0]};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input cplx_t a, input cplx_t b,
                               input cplx_t c, input cplx_t d);
    bus.valid_in = v;
    bus.x0_in    = a;
    bus.x1_in    = b;
    bus.x2_in    = c;
    bus.x3_in    = d;
  endtask

  task automatic checkOutput(input string tag, input cplx_t obs, input cplx_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed re=%0d im=%0d expected re=%0d im=%0d", tag,
             $signed(obs[WIDTH-1:HALF]), $signed(obs[HALF-1:0]),
             $signed(exp[WIDTH-1:HALF]), $signed(exp[HALF-1:0]));
    end
  endtask

  task automatic checkFlag(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkFrame(input string tag, input cplx_t e0, input cplx_t e1,
                            input cplx_t e2, input cplx_t e3);
    checkOutput({tag, "_x0"}, bus.x0_out, e0);
    checkOutput({tag, "_x1"}, bus.x1_out, e1);
    checkOutput({tag, "_x2"}, bus.x2_out, e2);
    checkOutput({tag, "_x3"}, bus.x3_out, e3);
  endtask

  // Present one frame for a single edge, then idle until it reaches P2.
  task automatic runFrame(input cplx_t a, input cplx_t b, input cplx_t c, input cplx_t d);
    applyStimulus(1'b1, a, b, c, d);
    tick;
    applyStimulus(1'b0, '0, '0, '0, '0);
    tick;
    tick;
  endtask

  initial begin
    logic       seen;
    logic [8:0] vpat;
    cplx_t      z;
    z = '0;

    // Reset state while held.
    rst = 1'b0;
    bus.stall = 1'b0;
    applyStimulus(1'b0, z, z, z, z);
    #2;
    checkFrame("reset", z, z, z, z);
    checkFlag("reset_valid", bus.valid_out, 1'b0);
    checkFlag("reset_stall_out", bus.stall_out, 1'b0);
    tick;
    tick;
    rst = 1'b1;
    tick;

    // Impulse at X0 with latency probe.
    applyStimulus(1'b1, cx(1024, 0), z, z, z);
    tick;
    applyStimulus(1'b0, z, z, z, z);
    tick;
    checkFlag("imp_lat2", bus.valid_out, 1'b0);
    tick;
    checkFlag("imp_valid", bus.valid_out, 1'b1);
    checkFrame("imp", cx(1024/SCL, 0), cx(1024/SCL, 0), cx(1024/SCL, 0), cx(1024/SCL, 0));
    tick;
    checkFlag("imp_after", bus.valid_out, 1'b0);

    // Single bin X1.
    runFrame(z, cx(1024, 0), z, z);
    checkFlag("bin1_valid", bus.valid_out, 1'b1);
    checkFrame("bin1", cx(1024/SCL, 0), cx(0, 1024/SCL), cx(-1024/SCL, 0), cx(0, -1024/SCL));

    // All bins equal: unscaled build saturates x0.
    runFrame(cx(1024, 0), cx(1024, 0), cx(1024, 0), cx(1024, 0));
`ifdef IFFT4_SCALE_EN
    checkFrame("sat", cx(1024, 0), z, z, z);
`else
    checkFrame("sat", cx(2047, 0), z, z, z);
`endif

    // X1 = (0,-2048): +j rotation must clamp -(-2048) to +2047.
    runFrame(z, cx(0, -2048), z, z);
`ifdef IFFT4_SCALE_EN
    checkFrame("negj", cx(0, -512), cx(512, 0), cx(0, 512), cx(-512, 0));
`else
    checkFrame("negj", cx(0, -2048), cx(2047, 0), cx(0, 2047), cx(-2047, 0));
`endif
    tick;
    tick;

    // Three frames with a two-cycle stall after the first result.
    applyStimulus(1'b1, cx(400, 0), z, z, z);
    tick;
    applyStimulus(1'b1, cx(0, 800), z, z, z);
    tick;
    applyStimulus(1'b1, cx(-400, 0), z, z, z);
    tick;
    checkFlag("stl_a_valid", bus.valid_out, 1'b1);
    checkOutput("stl_a", bus.x2_out, cx(400/SCL, 0));
    applyStimulus(1'b0, z, z, z, z);
    bus.stall = 1'b1;
    tick;
    checkFlag("stl_hold1_valid", bus.valid_out, 1'b1);
    checkOutput("stl_hold1", bus.x1_out, cx(400/SCL, 0));
    checkFlag("stl_out_d1", bus.stall_out, 1'b0);
    tick;
    checkOutput("stl_hold2", bus.x3_out, cx(400/SCL, 0));
    checkFlag("stl_out_d2", bus.stall_out, 1'b1);
    bus.stall = 1'b0;
    tick;
    checkFlag("stl_b_valid", bus.valid_out, 1'b1);
    checkFrame("stl_b", cx(0, 800/SCL), cx(0, 800/SCL), cx(0, 800/SCL), cx(0, 800/SCL));
    checkFlag("stl_out_d3", bus.stall_out, 1'b1);
    tick;
    checkFlag("stl_c_valid", bus.valid_out, 1'b1);
    checkFrame("stl_c", cx(-400/SCL, 0), cx(-400/SCL, 0), cx(-400/SCL, 0), cx(-400/SCL, 0));
    checkFlag("stl_out_d4", bus.stall_out, 1'b0);
    tick;
    checkFlag("stl_drain", bus.valid_out, 1'b0);

    // Asynchronous reset between edges with frames in flight.
    applyStimulus(1'b1, cx(800, 0), z, z, z);
    tick;
    applyStimulus(1'b1, cx(0, -400), z, z, z);
    tick;
    applyStimulus(1'b1, cx(400, 0), z, z, z);
    tick;
    checkFlag("rst_pre_valid", bus.valid_out, 1'b1);
    applyStimulus(1'b0, z, z, z, z);
    #2;
    rst = 1'b0;
    #1;
    checkFlag("rst_async_valid", bus.valid_out, 1'b0);
    checkFrame("rst_async", z, z, z, z);
    tick;
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (bus.valid_out !== 1'b0 || bus.x0_out !== z) seen = 1'b1;
    end
    checkFlag("rst_no_ghost", seen, 1'b0);
    applyStimulus(1'b1, cx(0, 400), z, z, z);
    tick;
    applyStimulus(1'b0, z, z, z, z);
    tick;
    checkFlag("rst_first_lat2", bus.valid_out, 1'b0);
    tick;
    checkFlag("rst_first_valid", bus.valid_out, 1'b1);
    checkOutput("rst_first", bus.x1_out, cx(0, 400/SCL));
    tick;
    tick;

    // Alternating valid bubbles, observed three edges later.
    vpat = '0;
    for (int i = 0; i < 11; i++) begin
      if (i < 8) applyStimulus((i % 2) == 0, cx(400, 0), z, z, z);
      else       applyStimulus(1'b0, z, z, z, z);
      tick;
      if (i >= 2) vpat[i-2] = bus.valid_out;
    end
    checkOutput("bubble_pattern", {15'd0, vpat}, {15'd0, 9'b001010101});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifft4.md
# ifft4

Four-point inverse FFT, the companion of the forward 4-point FFT in the accelerator datapath. Takes four packed complex frequency bins in parallel and returns four time-domain samples in natural order after a fixed three-cycle pipeline. It uses the same stall/stall_out pipeline-hold scheme as the forward transform, so it sits directly downstream of it or of any block using that scheme.

## Interface
- width, 24, packed complex sample width: {re[width-1:width/2], im[width/2-1:0]}, each half signed two's complement Q1.11.
- size, 4, transform length; fixed at 4, no other value supported.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- stall  in  1  high: every pipeline register holds.
- valid_in  in  1  x*_in carry a frame this cycle.
- x0_in..x3_in  in  width each  bins X[0]..X[3].
- valid_out  out  1  x*_out carry a frame.
- stall_out  out  1  stall delayed by LOG2(size)=2 cycles.
- x0_out..x3_out  out  width each  samples x[0]..x[3], natural order.

## Operation
- Pipeline: input register (P0) -> butterfly stage 0 (P1) -> butterfly stage 1 (P2), all registered.
- Stage 0 pairs (0,2) and (1,3):
  - a1[0]=X0+X2, a1[2]=X0-X2
  - a1[1]=X1+X3, a1[3]=+j·(X1-X3)
- Stage 1:
  - a2[0]=a1[0]+a1[1], a2[1]=a1[0]-a1[1]
  - a2[2]=a1[2]+a1[3], a2[3]=a1[2]-a1[3]
- Output map: x0_out=a2[0], x1_out=a2[2], x2_out=a2[1], x3_out=a2[3] (bit reversal applied inside the block).
- +j multiply is exact, with no multiplier: (re,im) -> (-im, re). Negating -2048 saturates to +2047.
- Arithmetic: each add/sub is done per half at 13 bits, then reduced to 12 bits per the Configuration rule.
- valid_in travels down a 3-bit valid shift register alongside the data. Frames with valid_in=0 still propagate data, but valid_out=0 for them.

## Timing
- Reset (rst=0, async): all data registers, the valid pipe and the stall_out pipe go to 0. While held in reset, x*_out=0, valid_out=0, stall_out=0.
- Latency: with stall low, a frame sampled at edge n appears on x*_out/valid_out after edge n+3.
- Throughput: one frame per cycle when stall=0.
- stall=1 at an edge: P0, P1, P2, the valid pipe and the output registers all hold. The stalled input frame is not captured, so the source must hold its inputs.
- stall_out pipe is never frozen; it shifts every cycle.
- Back-to-back stall toggles: no frame is duplicated or lost. Each valid frame produces exactly one valid_out cycle per non-stalled advance.
- Reset mid-frame: in-flight frames are discarded. The first valid_out after release comes 3 unstalled cycles after the first accepted valid_in.

## Configuration
- IFFT4_SCALE_EN defined: each stage's 13-bit result is reduced as (s+1)>>>1, an arithmetic shift rounding half toward +inf. The overall output is the true IDFT = (1/4)·sum X[k]·e^{+j2πkn/4}. This mode never overflows.
- IFFT4_SCALE_EN undefined: each stage saturates the 13-bit result to [-2048, +2047]. The output is the unscaled sum.

## Structure
- Shared package/header holds:
  - half-width localparam (width/2)
  - SAT12 and RND_SHR1 helper macros
  - the LOG2 macro already in macros.h
- One sub-module, ibfly2: a registered inverse butterfly with a stall hold and a mul_j select input. Four instances are used.
- The stall_out delay line stays inline; it is only 2 flops.

## Test plan
- Impulse, SCALE_EN: X0=(1024,0), others 0 -> all four outputs (256,0), with valid_out exactly 3 cycles after valid_in.
- Single bin, SCALE_EN: X1=(1024,0), others 0 -> x0..x3 = (256,0), (0,256), (-256,0), (0,-256).
- Saturation, no SCALE_EN: all inputs (1024,0) -> x0_out=(2047,0) (saturated), x1..x3=(0,0).
- Stall: stream 3 distinct frames, assert stall for 2 cycles mid-stream -> the same 3 results in order, no duplicates or drops; stall_out follows stall 2 cycles later.
- Reset mid-operation: drive rst=0 asynchronously between edges with 2 frames in flight -> outputs and valid_out go to 0 immediately; neither discarded frame ever appears after release.
- Valid bubbles: alternate valid_in 1/0 over 8 cycles -> valid_out reproduces the 1/0 pattern delayed by 3 cycles.
